winograd_acc: RTL

WINOGRAD_ACC -- requirements
Module: winograd_acc

---
 rtl/winograd_acc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/winograd_acc.sv
// winograd_acc: streaming dot-product accumulator using the Winograd pairwise product form
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   valid_i / ready_o       beat handshake (ready_o = !valid_o || ready_i)
//   last_i                  final beat of the current vector
//   signed_i                operand mode, sampled on the first beat of a vector
//   in_0_i, in_1_i          ARRAY_SIZE operand pairs per beat
//   valid_o / ready_i       result handshake
//   out_o                   dot product modulo 2^ACC_SIZE
//   beats_o                 number of beats in the result's vector
//   overflow_o              sticky accumulation overflow of the result's vector
module winograd_acc #(
   parameter int IN_SIZE_0  = 4,
   parameter int IN_SIZE_1  = 8,
   parameter int ARRAY_SIZE = 8,
   parameter int MAX_BEATS  = 16,
   parameter int ACC_SIZE   = 32
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic                                      valid_i,
   output logic                                      ready_o,
   input  logic                                      last_i,
   input  logic                                      signed_i,
   input  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0]      in_0_i,
   input  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0]      in_1_i,
   output logic                                      valid_o,
   input  logic                                      ready_i,
   output logic [ACC_SIZE-1:0]                       out_o,
   output logic [$clog2(MAX_BEATS+1)-1:0]            beats_o,
   output logic                                      overflow_o
);
   localparam int CW = $clog2(MAX_BEATS+1);
   localparam int MW = IN_SIZE_0 > IN_SIZE_1 ? IN_SIZE_0 : IN_SIZE_1;
   // per-beat arithmetic width: pair sums, their products and the reduction tree
   localparam int PW = 2*MW + $clog2(ARRAY_SIZE) + 6;
   // accumulation width wide enough to tell an out-of-range result from a wrapped one
   localparam int XW = (ACC_SIZE > PW ? ACC_SIZE : PW) + 2;

   typedef enum logic {IDLE, ACCUM} state_e;

   state_e                                 state_q, state_d;
   logic [CW-1:0]                          cnt_q, cnt_d, num;
   logic                                   mode_q, mode_d;
   logic                                   s1_v_q, s1_v_d, s1_last_q, s1_last_d;
   logic                                   s1_first_q, s1_first_d, s1_mode_q, s1_mode_d;
   logic [CW-1:0]                          s1_num_q, s1_num_d;
   logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0]   s1_a_q, s1_a_d;
   logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0]   s1_b_q, s1_b_d;
   logic [ACC_SIZE-1:0]                    acc_q, acc_d, out_q, out_d;
   logic                                   ovf_q, ovf_d, valid_q, valid_d, oflag_q, oflag_d;
   logic [CW-1:0]                          beats_q, beats_d;
   logic                                   take, last_eff, fits;
   logic signed [PW-1:0]                   ax [ARRAY_SIZE];
   logic signed [PW-1:0]                   bx [ARRAY_SIZE];
   logic signed [PW-1:0]                   bsum;
   logic signed [XW-1:0]                   base, tot;

   assign ready_o    = !valid_q || ready_i;
   assign take       = valid_i && ready_o;
   assign num        = cnt_q + CW'(1);
   assign last_eff   = last_i || num == CW'(MAX_BEATS);
   assign valid_o    = valid_q;
   assign out_o      = out_q;
   assign beats_o    = beats_q;
   assign overflow_o = oflag_q;

   // a0*b0 + a1*b1 = (a0+b1)*(a1+b0) - a0*a1 - b0*b1, one multiplier per pair plus corrections
   always_comb begin
      bsum = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         ax[i] = {{(PW-IN_SIZE_0){s1_mode_q & s1_a_q[i][IN_SIZE_0-1]}}, s1_a_q[i]};
         bx[i] = {{(PW-IN_SIZE_1){s1_mode_q & s1_b_q[i][IN_SIZE_1-1]}}, s1_b_q[i]};
      end
      for (int j = 0; j < ARRAY_SIZE/2; j++)
         bsum = bsum + (ax[2*j] + bx[2*j+1]) * (ax[2*j+1] + bx[2*j])
                     - ax[2*j] * ax[2*j+1] - bx[2*j] * bx[2*j+1];
      base = s1_first_q ? '0 : {{(XW-ACC_SIZE){s1_mode_q & acc_q[ACC_SIZE-1]}}, acc_q};
      tot  = base + {{(XW-PW){bsum[PW-1]}}, bsum};
      // in range when the bits above the result are a pure sign (signed) or zero (unsigned) extension
      fits = s1_mode_q ? (&tot[XW-1:ACC_SIZE-1] | ~|tot[XW-1:ACC_SIZE-1]) : ~|tot[XW-1:ACC_SIZE];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      s1_v_d     = s1_v_q;
      s1_last_d  = s1_last_q;
      s1_first_d = s1_first_q;
      s1_mode_d  = s1_mode_q;
      s1_num_d   = s1_num_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      valid_d    = valid_q;
      out_d      = out_q;
      beats_d    = beats_q;
      oflag_d    = oflag_q;
      // the whole pipeline advances only when the output register can take a result
      if (ready_o) begin
         s1_v_d  = take;
         valid_d = 1'b0;
         if (take) begin
            s1_a_d     = in_0_i;
            s1_b_d     = in_1_i;
            s1_last_d  = last_eff;
            s1_first_d = state_q == IDLE;
            s1_mode_d  = state_q == IDLE ? signed_i : mode_q;
            s1_num_d   = num;
            mode_d     = s1_mode_d;
            cnt_d      = last_eff ? '0 : num;
            state_d    = last_eff ? IDLE : ACCUM;
         end
         if (s1_v_q) begin
            acc_d = tot[ACC_SIZE-1:0];
            ovf_d = (!s1_first_q && ovf_q) || !fits;
            if (s1_last_q) begin
               valid_d = 1'b1;
               out_d   = acc_d;
               beats_d = s1_num_q;
               oflag_d = ovf_d;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         s1_v_q     <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_first_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_num_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         out_q      <= '0;
         beats_q    <= '0;
         oflag_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         s1_v_q     <= s1_v_d;
         s1_last_q  <= s1_last_d;
         s1_first_q <= s1_first_d;
         s1_mode_q  <= s1_mode_d;
         s1_num_q   <= s1_num_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         out_q      <= out_d;
         beats_q    <= beats_d;
         oflag_q    <= oflag_d;
      end
   end
endmodule
